// File: rtl/interval_meter.sv
// ---------------------------------------------------------------------------
// interval_meter
//
// Multi-channel edge-to-edge interval meter. A reference edge starts a tick
// counter; the next edge on the selected stop channel stops it. The tick
// count is scaled by TICK_NS and published on interval_ns.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   sig_ref      asynchronous reference input
//   sig_ch       asynchronous stop inputs, one per channel
//   ch_sel       stop channel select (captured at measurement start)
//   edge_sel     0 = falling edges, 1 = rising edges (captured at start)
//   interval_ns  last valid result, ticks x TICK_NS truncated to OUT_W
//   valid        one-cycle pulse when interval_ns updates
//   timeout      one-cycle pulse when a measurement is aborted
//   busy         high whenever the measurement FSM is not idle
//
// Optional feature macro: INTERVAL_AVG_EN
//   When defined, successful tick results are summed over 8 measurements
//   and only the average of each block of eight is published. A timeout
//   discards the partial block.
// ---------------------------------------------------------------------------
module interval_meter #(
  parameter int     CH            = 4,
  parameter int     CNT_W         = 32,
  parameter int     OUT_W         = 40,
  parameter int     TICK_NS       = 5,
  parameter longint TIMEOUT_TICKS = 200_000_000,
  localparam int    SEL_W         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_ref,
  input  logic [CH-1:0]    sig_ch,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic             edge_sel,
  output logic [OUT_W-1:0] interval_ns,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TMO_LIM   = CNT_W'(TIMEOUT_TICKS);
  localparam logic [OUT_W-1:0] TICK_MULT = OUT_W'(TICK_NS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    TMO   = 2'd3
  } state_t;

  state_t state, state_next;

  logic             ref_s1, ref_s2, ref_hist;
  logic [CH-1:0]    ch_s1, ch_s2, ch_hist;
  logic             ref_pulse;
  logic [CH-1:0]    ch_pulse;
  logic             stop_pulse;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] ticks;
  logic [SEL_W-1:0] sel_ch_q;
  logic             sel_edge_q;

  logic [CNT_W-1:0] result_ticks;
  logic             publish;

  // Reference and stop inputs share the same sync + history structure so
  // their pin-to-pulse latency is identical and cancels in the interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_s1   <= 1'b0;
      ref_s2   <= 1'b0;
      ref_hist <= 1'b0;
      ch_s1    <= '0;
      ch_s2    <= '0;
      ch_hist  <= '0;
    end else begin
      ref_s1   <= sig_ref;
      ref_s2   <= ref_s1;
      ref_hist <= ref_s2;
      ch_s1    <= sig_ch;
      ch_s2    <= ch_s1;
      ch_hist  <= ch_s2;
    end
  end

  // The reference polarity follows the live edge_sel (only used in IDLE);
  // stop polarity follows the value captured when the measurement started.
  assign ref_pulse = edge_sel   ? (ref_s2 & ~ref_hist) : (~ref_s2 & ref_hist);
  assign ch_pulse  = sel_edge_q ? (ch_s2 & ~ch_hist)   : (~ch_s2 & ch_hist);

  // Decoded by comparison rather than indexing so that a select value with
  // no matching channel simply never produces a stop.
  always_comb begin
    stop_pulse = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (sel_ch_q == SEL_W'(i)) stop_pulse = ch_pulse[i];
    end
  end

  assign cnt_inc = cnt + 1'b1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A stop in the same cycle as the timeout condition takes priority.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ref_pulse) state_next = COUNT;
      COUNT: begin
        if (stop_pulse)              state_next = DONE;
        else if (cnt_inc == TMO_LIM) state_next = TMO;
      end
      DONE:    state_next = IDLE;
      TMO:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef INTERVAL_AVG_EN
  logic [2:0]       sample_cnt;
  logic [CNT_W+2:0] acc;
  logic [CNT_W+2:0] acc_sum;

  assign acc_sum      = acc + {3'b000, ticks};
  assign result_ticks = acc_sum[CNT_W+2:3];
  assign publish      = (sample_cnt == 3'd7);

  // The eighth sample is folded into the published average directly, so
  // the accumulator clears instead of storing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= 3'd0;
      acc        <= '0;
    end else if (state == TMO) begin
      sample_cnt <= 3'd0;
      acc        <= '0;
    end else if (state == DONE) begin
      if (publish) begin
        sample_cnt <= 3'd0;
        acc        <= '0;
      end else begin
        sample_cnt <= sample_cnt + 3'd1;
        acc        <= acc_sum;
      end
    end
  end
`else
  assign result_ticks = ticks;
  assign publish      = 1'b1;
`endif

  // Counting, shadow capture and result registers. The tick count is
  // cnt + 1 at the stop so that a stop D cycles after the start gives D.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      ticks       <= '0;
      sel_ch_q    <= '0;
      sel_edge_q  <= 1'b0;
      interval_ns <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_pulse) begin
            cnt        <= '0;
            sel_ch_q   <= ch_sel;
            sel_edge_q <= edge_sel;
          end
        end
        COUNT: begin
          cnt <= cnt_inc;
          if (stop_pulse) ticks <= cnt_inc;
        end
        DONE: begin
          if (publish) begin
            interval_ns <= OUT_W'(result_ticks) * TICK_MULT;
            valid       <= 1'b1;
          end
        end
        TMO: begin
          timeout <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_meter.sv
// ---------------------------------------------------------------------------
// tb_interval_meter
//
// Bench for interval_meter (CH=3, TIMEOUT_TICKS=120, TICK_NS=5). Inputs are
// changed 1 time unit after a rising clock edge; outputs are sampled on the
// falling edge. Each measurement drives one reference edge at step 0 and a
// per-step stop waveform, then checks pulse counts, the result, busy and the
// cycle latency from reference pin change to the output pulse.
// ---------------------------------------------------------------------------
module tb_interval_meter;

  localparam int CH      = 3;
  localparam int CNT_W   = 16;
  localparam int OUT_W   = 24;
  localparam int TICK_NS = 5;
  localparam int TMO     = 120;
  localparam int SEL_W   = 2;
  localparam int L       = TMO + 6;
  localparam int PIPE    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_ref;
  logic [CH-1:0]    sig_ch;
  logic [SEL_W-1:0] ch_sel;
  logic             edge_sel;
  logic [OUT_W-1:0] interval_ns;
  logic             valid;
  logic             timeout;
  logic             busy;

  interval_meter #(
    .CH(CH), .CNT_W(CNT_W), .OUT_W(OUT_W), .TICK_NS(TICK_NS),
    .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .sig_ref(sig_ref), .sig_ch(sig_ch),
    .ch_sel(ch_sel), .edge_sel(edge_sel), .interval_ns(interval_ns),
    .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_cnt = 0, tmo_cnt = 0;
  int last_valid_cyc = -1, last_tmo_cyc = -1;

  logic [CH-1:0] wave [L];
  logic [CH-1:0] base;

  typedef struct {
    string  name;
    int     es, sel, stop_ch, stop_at, stop2_at, decoy_ch, decoy_at;
    int     chg_at, chg_sel;
    int     exp_valid, exp_tmo;
    longint exp_ns;
    int     exp_lat;
  } vec_t;

  vec_t tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1)   begin valid_cnt++; last_valid_cyc = cyc; end
    if (timeout === 1'b1) begin tmo_cnt++;   last_tmo_cyc   = cyc; end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Idle the inputs at the inactive level for the chosen polarity, then
  // fire the reference edge at step 0 and play the stop waveform.
  task automatic applyStimulus(input int es, input int sel, input int chg_at,
                               input int chg_sel, output int ref_cyc,
                               output int v0, output int t0);
    step(1);
    edge_sel = es[0];
    ch_sel   = SEL_W'(sel);
    sig_ref  = ~es[0];
    sig_ch   = base;
    step(5);
    v0 = valid_cnt;
    t0 = tmo_cnt;
    ref_cyc = cyc;
    for (int d = 0; d < L; d++) begin
      if (d > 0) step(1);
      if (d == 0) sig_ref = es[0];
      sig_ch = wave[d];
      if (d == chg_at) ch_sel = SEL_W'(chg_sel);
    end
    step(8);
  endtask

  task automatic checkScenario(input string name, input int exp_valid,
                               input int exp_tmo, input longint exp_ns,
                               input int exp_lat, input int ref_cyc,
                               input int v0, input int t0);
    checkOutput({name, " valid_count"},   valid_cnt - v0, exp_valid);
    checkOutput({name, " timeout_count"}, tmo_cnt - t0, exp_tmo);
    checkOutput({name, " interval_ns"},   interval_ns, exp_ns);
    checkOutput({name, " busy_after"},    busy, 0);
    if (exp_valid != 0)
      checkOutput({name, " valid_latency"}, last_valid_cyc - ref_cyc, exp_lat);
    if (exp_tmo != 0)
      checkOutput({name, " timeout_latency"}, last_tmo_cyc - ref_cyc, exp_lat);
  endtask

  // Stop events are two-step pulses to the active level on top of an
  // all-inactive baseline.
  task automatic buildWave(input vec_t v);
    logic [CH-1:0] w;
    base = v.es[0] ? '0 : '1;
    for (int d = 0; d < L; d++) begin
      w = base;
      if (v.stop_at  >= 0 && (d == v.stop_at  || d == v.stop_at  + 1)) w[v.stop_ch]  = v.es[0];
      if (v.stop2_at >= 0 && (d == v.stop2_at || d == v.stop2_at + 1)) w[v.stop_ch]  = v.es[0];
      if (v.decoy_at >= 0 && (d == v.decoy_at || d == v.decoy_at + 1)) w[v.decoy_ch] = v.es[0];
      wave[d] = w;
    end
  endtask

  function automatic vec_t mk(string n, int es, int sel, int sch, int sat,
                              int s2, int dch, int dat, int cat, int csel,
                              int ev, int et, longint ens, int elat);
    vec_t v;
    v.name = n; v.es = es; v.sel = sel; v.stop_ch = sch; v.stop_at = sat;
    v.stop2_at = s2; v.decoy_ch = dch; v.decoy_at = dat; v.chg_at = cat;
    v.chg_sel = csel; v.exp_valid = ev; v.exp_tmo = et; v.exp_ns = ens;
    v.exp_lat = elat;
    return v;
  endfunction

  initial begin
    int     ref_cyc, v0, t0;
    int     es, sel, chg_at, chg_sel, found, ev, et, lat;
    longint model_ns;
    int     samples[$];
    logic [CH-1:0] lvl, prev;

`ifdef INTERVAL_AVG_EN
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk($sformatf("avg_a%0d", i), 0, 1, 1, (i < 4) ? 10 : 12,
                       -1, 0, -1, -1, 0, (i == 7) ? 1 : 0, 0,
                       (i == 7) ? 55 : 0, 16));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("avg_b%0d", i), 1, 0, 0, 10,
                       -1, 0, -1, -1, 0, 0, 0, 55, 14));
    tbl.push_back(mk("avg_timeout", 1, 0, 0, -1, -1, 0, -1, -1, 0, 0, 1, 55, TMO + PIPE));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk($sformatf("avg_c%0d", i), 0, 2, 2, 20,
                       -1, 0, -1, -1, 0, (i == 7) ? 1 : 0, 0,
                       (i == 7) ? 100 : 55, 24));
`else
    tbl.push_back(mk("single",        0, 2, 2, 100, -1, 0, -1, -1, 0, 1, 0, 500, 104));
    tbl.push_back(mk("isolate",       1, 1, 1, 37,  -1, 0, 10, 20, 0, 1, 0, 185, 41));
    tbl.push_back(mk("timeout",       1, 0, 0, -1,  -1, 0, -1, -1, 0, 0, 1, 185, TMO + PIPE));
    tbl.push_back(mk("stop_at_limit", 0, 1, 1, 120, -1, 0, -1, -1, 0, 1, 0, 600, 124));
    tbl.push_back(mk("past_limit",    0, 1, 1, 121, -1, 0, -1, -1, 0, 0, 1, 600, TMO + PIPE));
    tbl.push_back(mk("simultaneous",  1, 0, 0, 0,   7,  0, -1, -1, 0, 1, 0, 35,  11));
    tbl.push_back(mk("out_of_range",  1, 3, 2, 5,   -1, 0, 9,  -1, 0, 0, 1, 35,  TMO + PIPE));
    tbl.push_back(mk("min_delay",     0, 0, 0, 1,   -1, 0, -1, -1, 0, 1, 0, 5,   5));
    tbl.push_back(mk("wrong_channel", 0, 2, 2, 50,  -1, 1, 4,  -1, 0, 1, 0, 250, 54));
`endif

    // Reset values
    rst = 1'b1; sig_ref = 1'b0; sig_ch = '0; edge_sel = 1'b0; ch_sel = '0;
    step(3);
    checkOutput("reset interval_ns", interval_ns, 0);
    checkOutput("reset valid", valid, 0);
    checkOutput("reset timeout", timeout, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b0;
    step(3);

    // Reset mid-measurement, with a stop edge while reset is held
    edge_sel = 1'b0; ch_sel = 2'd2; sig_ref = 1'b1; sig_ch = '1;
    step(6);
    sig_ref = 1'b0;
    step(10);
    checkOutput("rstmid busy_counting", busy, 1);
    rst = 1'b1;
    step(2);
    sig_ch[2] = 1'b0;
    step(6);
    checkOutput("rstmid busy_in_reset", busy, 0);
    rst = 1'b0;
    step(12);
    checkOutput("rstmid busy_after", busy, 0);
    checkOutput("rstmid interval_ns", interval_ns, 0);
    checkOutput("rstmid valid_count", valid_cnt, 0);
    checkOutput("rstmid timeout_count", tmo_cnt, 0);

    // Directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      buildWave(tbl[i]);
      applyStimulus(tbl[i].es, tbl[i].sel, tbl[i].chg_at, tbl[i].chg_sel, ref_cyc, v0, t0);
      checkScenario(tbl[i].name, tbl[i].exp_valid, tbl[i].exp_tmo, tbl[i].exp_ns,
                    tbl[i].exp_lat, ref_cyc, v0, t0);
    end
    model_ns = tbl[tbl.size()-1].exp_ns;

    // Randomized measurements against the reference model: the result is
    // the first selected-polarity transition on the captured channel at a
    // step 1..TMO after the reference edge, otherwise a timeout.
    for (int r = 0; r < 16; r++) begin
      es      = $urandom_range(0, 1);
      sel     = $urandom_range(0, 3);
      chg_at  = $urandom_range(10, 60);
      chg_sel = $urandom_range(0, 3);
      base    = CH'($urandom);
      lvl     = base;
      for (int d = 0; d < L; d++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, 29) == 0) lvl[c] = ~lvl[c];
        wave[d] = lvl;
      end

      found = -1;
      if (sel < CH) begin
        for (int d = 1; d <= TMO && found < 0; d++) begin
          prev = wave[d-1];
          if (es == 1 && !prev[sel] && wave[d][sel]) found = d;
          if (es == 0 && prev[sel] && !wave[d][sel]) found = d;
        end
      end

      ev = 0; et = 0; lat = 0;
      if (found > 0) begin
        lat = found + PIPE;
`ifdef INTERVAL_AVG_EN
        samples.push_back(found);
        if (samples.size() == 8) begin
          longint sum = 0;
          foreach (samples[k]) sum += samples[k];
          model_ns = (sum / 8) * TICK_NS;
          ev = 1;
          samples.delete();
        end
`else
        model_ns = longint'(found) * TICK_NS;
        ev = 1;
`endif
      end else begin
        et = 1;
        lat = TMO + PIPE;
        samples.delete();
      end

      applyStimulus(es, sel, chg_at, chg_sel, ref_cyc, v0, t0);
      checkScenario($sformatf("rand%0d", r), ev, et, model_ns, lat, ref_cyc, v0, t0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
